pipelined_rca_adder: RTL
========================

// Module: pipelined_rca_adder
// PURPOSE
//   Parametrised, pipelined ripple-carry adder: next generation of the half/full-adder RCA blocks.
//   Splits a WIDTH-bit add into STAGES registered ripple segments, with a valid/ready stream handshake
//   and backpressure. Sits between operand producers and result consumers in the arithmetic datapath.
// PARAMETERS
//   WIDTH   16  operand/sum width in bits; must satisfy WIDTH % STAGES == 0 (elaboration $error otherwise)
//   STAGES  4   pipeline segments, 1..WIDTH; SEG = WIDTH/STAGES bits rippled per stage
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operand beat present
//   in_ready   out  1      block accepts beat this cycle
//   a          in   WIDTH  operand A (unsigned or two's complement)
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in
//   sub        in   1      subtract select (only with ADDER_SUB_EN)
//   out_valid  out  1      result beat present
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result bits
//   cout       out  1      carry out of MSB
//   ovf        out  1      signed overflow (only with ADDER_SUB_EN)
// BEHAVIOUR
//   - Global advance: adv = !out_valid | out_ready; in_ready = adv (combinational, no in_valid dependency).
//   - Beat accepted when in_valid & in_ready. On adv every stage register loads from its predecessor;
//     stage0 loads {valid=in_valid, a, b, cin}. On !adv all stage registers hold.
//   - Stage k (0..STAGES-1) ripples bits [k*SEG +: SEG] using the carry registered by stage k-1
//     (stage0 uses cin). Finished low sum bits and unconsumed high operand bits move forward skewed.
//   - Latency: exactly STAGES cycles accept->out_valid with out_ready held high; throughput 1 beat/clk.
//   - Bubbles (in_valid=0 on adv) propagate as valid=0 slots; no bubble collapsing.
//   - Under stall, sum/cout/ovf/out_valid hold stable until out_ready; no beat dropped or duplicated.
//   - Result ordering strictly FIFO; sum = (a + b + cin) mod 2^WIDTH, cout = bit WIDTH of that sum.
//   - Reset (any time, incl. mid-flight): all stage valids 0, all data registers 0; out_valid=0,
//     sum=0, cout=0, ovf=0; in_ready=1 during and after reset. In-flight beats discarded.
//   - STAGES=1: single registered stage, latency 1. STAGES=WIDTH: one bit per stage.
// CONFIGURATION
//   ADDER_SUB_EN defined: ports sub and ovf exist. sub=1 -> b inverted at stage0, effective carry-in
//     forced 1 (cin ignored); sub=0 -> plain add with cin. ovf = carry into MSB XOR cout, registered
//     alongside sum. sub travels with its beat.
//   ADDER_SUB_EN undefined: no sub/ovf ports; add-only, cin used directly.
// STRUCTURE
//   Shared package pipelined_rca_pkg: default WIDTH/STAGES constants, SEG computation function,
//   stage-register struct typedef {valid, sum_lo, a_hi, b_hi, carry, sub}.
//   Sub-module rca_segment (combinational, SEG-bit ripple of full adders built from ha cells),
//   instantiated STAGES times via generate; top holds only registers and handshake.
// TESTING
//   1. WIDTH=16,STAGES=4: a=FFFF,b=0001,cin=0, out_ready=1 -> after 4 clk sum=0000,cout=1,out_valid=1.
//   2. 8 back-to-back beats (a=i,b=2i, i=1..8) -> 8 consecutive out_valid cycles, sums 3,6,..,24 in order.
//   3. Stall: out_ready=0 for 3 clk with result pending -> sum/cout stable, in_ready=0; release -> resumes, no loss.
//   4. Reset asserted with 3 beats in flight -> out_valid=0, sum=0 immediately (async); no stale beat after release.
//   5. ADDER_SUB_EN: 0005-0007 -> FFFE,cout=0,ovf=0; 8000-0001 -> 7FFF,cout=1,ovf=1.
//   6. STAGES=1 and STAGES=16 builds: random 1000 beats with random out_ready vs model, zero mismatches.

Source files
------------

// File: rtl/pipelined_rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder.
// Holds the default geometry, the segment-width helper, the geometry
// legality check and the half-adder cell the segments are built from.
package pipelined_rca_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  // Bits rippled by each pipeline segment.
  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Every segment must be the same width and hold at least one bit.
  function automatic bit geometry_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  // Half-adder cell: returns {carry, sum}.
  function automatic logic [1:0] ha(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

endpackage

// File: rtl/rca_segment.sv
// Combinational SEG-bit ripple-carry segment.
// Each bit is a full adder made of two half-adder cells and an OR.
// With ADDER_SUB_EN defined the carry into the segment MSB is exported so
// the last segment can form signed overflow.
module rca_segment
  import pipelined_rca_pkg::*;
#(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
`ifdef ADDER_SUB_EN
  ,
  output logic           c_msb
`endif
);

  for (genvar i = 0; i < SEG; i++) begin : g_fa
    logic       ci;
    logic       co;
    logic [1:0] h0;
    logic [1:0] h1;

    if (i == 0) begin : g_first
      assign ci = cin;
    end else begin : g_next
      assign ci = g_fa[i-1].co;
    end

    assign h0     = ha(a[i], b[i]);
    assign h1     = ha(h0[0], ci);
    assign sum[i] = h1[0];
    assign co     = h0[1] | h1[1];
  end

  assign cout = g_fa[SEG-1].co;

`ifdef ADDER_SUB_EN
  assign c_msb = g_fa[SEG-1].ci;
`endif

endmodule

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder with valid/ready stream handshake.
// A WIDTH-bit add is split into STAGES registered segments of SEG bits.
// Register k holds the finished low sum bits, the not-yet-used operand bits
// (shifted down so the next segment always reads bits [SEG-1:0]) and the
// carry out of segment k. The whole pipeline advances or stalls as one.
// Optional feature macro: ADDER_SUB_EN (adds sub input and ovf output).
module pipelined_rca_adder
  import pipelined_rca_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_SUB_EN
  ,
  output logic             ovf
`endif
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $error("pipelined_rca_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
  end

  // Widths depend on WIDTH, so the stage record lives here.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] sum_lo;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b_hi;
    logic             carry;
`ifdef ADDER_SUB_EN
    logic             ovf;
`endif
  } stage_t;

  stage_t stage_q [STAGES];
  stage_t stage_d [STAGES];

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Subtraction is folded into the operands at entry, so the beat's sub
  // select travels implicitly as the inverted b bits and forced carry.
`ifdef ADDER_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;

    logic             valid_src;
    logic [WIDTH-1:0] sum_src;
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic             carry_src;
    logic [SEG-1:0]   seg_sum;
    logic             seg_cout;
`ifdef ADDER_SUB_EN
    logic             seg_cmsb;
`endif
    stage_t           nxt;

    if (k == 0) begin : g_head
      assign valid_src = in_valid;
      assign sum_src   = '0;
      assign a_src     = a;
      assign b_src     = b_eff;
      assign carry_src = cin_eff;
    end else begin : g_body
      assign valid_src = stage_q[k-1].valid;
      assign sum_src   = stage_q[k-1].sum_lo;
      assign a_src     = stage_q[k-1].a_hi;
      assign b_src     = stage_q[k-1].b_hi;
      assign carry_src = stage_q[k-1].carry;
    end

    rca_segment #(
      .SEG (SEG)
    ) u_seg (
      .a    (a_src[SEG-1:0]),
      .b    (b_src[SEG-1:0]),
      .cin  (carry_src),
      .sum  (seg_sum),
      .cout (seg_cout)
`ifdef ADDER_SUB_EN
      ,
      .c_msb(seg_cmsb)
`endif
    );

    // Assemble the record this stage captures on the next advance.
    always_comb begin
      nxt                   = '0;
      nxt.valid             = valid_src;
      nxt.sum_lo            = sum_src;
      nxt.sum_lo[LO +: SEG] = seg_sum;
      nxt.a_hi              = a_src >> SEG;
      nxt.b_hi              = b_src >> SEG;
      nxt.carry             = seg_cout;
`ifdef ADDER_SUB_EN
      nxt.ovf               = seg_cmsb ^ seg_cout;
`endif
    end

    assign stage_d[k] = nxt;
  end

  // All stage registers load together on advance and hold together on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign out_valid = stage_q[STAGES-1].valid;
  assign sum       = stage_q[STAGES-1].sum_lo;
  assign cout      = stage_q[STAGES-1].carry;
`ifdef ADDER_SUB_EN
  assign ovf       = stage_q[STAGES-1].ovf;
`endif

endmodule
